pipe_stage_skid: RTL

//  Parametrised pipeline-stage register for CPU stage boundaries (ex->mem, mem->wb).

---
 rtl/pipe_stage_skid.sv | 87 ++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with valid/ready handshake, optional skid entry, free-running sideband and flush-drop counter
// Ports:
//   clk, cpurst_n                 clock (rising edge), asynchronous active-low reset
//   flush                         kill stored beats and the incoming beat this cycle
//   in_valid, in_ready, in_data   upstream handshake and payload
//   in_side, out_side             sideband, delayed one cycle regardless of stall/flush
//   out_valid, out_ready, out_data downstream handshake and head payload
//   occupancy                     stored beats (0..2)
//   drop_cnt                      saturating count of flush cycles that discarded a beat
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int SIDE_W = 32,
  parameter bit SKID = 1'b1,
  parameter bit ZERO_ON_FLUSH = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              cpurst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SIDE_W-1:0] out_side,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);
  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] head, skid, head_nx, skid_nx;
  logic accept, deliver, drop;
  assign out_valid = state != EMPTY;
  // with a skid entry, in_ready depends only on the state register
  assign in_ready  = SKID ? (state != FULL) : (~out_valid | out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign deliver   = out_valid & out_ready;
  assign occupancy = state;
  assign out_data  = head;
  assign drop      = flush & ((out_valid & ~deliver) | (state == FULL) | (in_valid & in_ready));
  always_comb begin
    state_nx = state;
    head_nx  = head;
    skid_nx  = skid;
    if (flush) begin
      state_nx = EMPTY;
      if (ZERO_ON_FLUSH) begin
        head_nx = '0;
        skid_nx = '0;
      end
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_nx = HALF;
          head_nx  = in_data;
        end
        HALF: if (accept && deliver) head_nx = in_data;
          else if (accept && SKID) begin
            state_nx = FULL;
            skid_nx  = in_data;
          end else if (deliver) state_nx = EMPTY;
        FULL: if (deliver) begin
          state_nx = HALF;
          head_nx  = skid;
        end
        default: state_nx = EMPTY;
      endcase
    end
  end
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state    <= EMPTY;
      head     <= '0;
      skid     <= '0;
      out_side <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_nx;
      head     <= head_nx;
      skid     <= skid_nx;
      out_side <= in_side;
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end
endmodule
